aes_round_seq: RTL and testbench
================================

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning round-datapath latency in cycles from RoundValid to RoundOut valid; legal range 1..15.
REQ-002 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start  input  1  request to encrypt the block on In.
REQ-005 SHALL have port In  input  128  plaintext block, sampled when Start is accepted.
REQ-006 SHALL have port RoundOut  input  128  result returned by the external round datapath (SubBytes/ShiftRows/MixColEnc/AddRoundKey).
REQ-007 SHALL have port RoundIn  output  128  state fed to the round datapath.
REQ-008 SHALL have port RoundNum  output  4  current round index 0..10; the datapath uses it to select the round key.
REQ-009 SHALL have port Mode  output  2  datapath mode: 0 = AddRoundKey only, 1 = full round, 2 = final round (MixColumns bypassed); 3 is never driven.
REQ-010 SHALL have port RoundValid  output  1  one-cycle strobe marking a new round issue.
REQ-011 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port Done  output  1  one-cycle strobe; Out is valid.
REQ-013 SHALL have port Out  output  128  ciphertext, held until the next completion.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-015 SHALL, in IDLE with Start=1, load In into the internal 128-bit state register St, set RoundNum=0, and go to ISSUE.
REQ-016 SHALL, in IDLE with Start=0, remain in IDLE.
REQ-017 SHALL ignore Start whenever Busy=1: no queueing, and St, RoundNum and Out are unaffected.
REQ-018 SHALL, in ISSUE, assert RoundValid for exactly one cycle and go to WAIT.
REQ-019 SHALL drive RoundIn=St continuously and hold it stable through ISSUE and WAIT.
REQ-020 SHALL derive Mode combinationally from RoundNum: 0 when RoundNum=0, 1 when RoundNum=1..9, 2 when RoundNum=10.
REQ-021 SHALL, in WAIT, count cycles with a 4-bit counter cleared on ISSUE.
REQ-022 SHALL, on the edge ending the LAT-th WAIT cycle, capture RoundOut into St.
REQ-023 SHALL, on that capture edge, go to DONE when RoundNum=10; otherwise increment RoundNum and go to ISSUE.
REQ-024 SHALL never wrap RoundNum past 10.
REQ-025 SHALL, on DONE entry, register Out=St (the final captured value).
REQ-026 SHALL assert Done for exactly one cycle in DONE, then return to IDLE; Start is not accepted in DONE.
REQ-027 SHALL use exactly LAT+1 cycles per round and run 11 rounds (0..10).
REQ-028 SHALL raise Done 11*(LAT+1) cycles after the Start-accept edge; this is 22 cycles for LAT=1.
REQ-029 SHALL accept the next Start in the first IDLE cycle after Done, giving back-to-back throughput of one block per 11*(LAT+1)+2 cycles.
REQ-030 SHALL keep Out unchanged from Done until the next Done, including during a subsequent encryption.
REQ-031 SHALL leave RoundIn and RoundNum holding their last values in IDLE, with Mode following RoundNum.

Reset
REQ-032 SHALL, on Rst_n low at any time including mid-operation, immediately force: state=IDLE, St=0, RoundNum=0, wait counter=0, Out=0, RoundValid=0, Busy=0, Done=0.
REQ-033 SHALL, while Rst_n is low, produce no RoundValid or Done pulse.
REQ-034 SHALL, after Rst_n deasserts, accept Start on the first rising edge.
REQ-035 SHALL NOT resume an operation that was interrupted by reset.

Verification
REQ-036 SHALL cover: stub datapath RoundOut = RoundIn XOR {124'b0,RoundNum} with LAT=1, In=128'h6353e08c0960e104cd70b751bacad0e7, one Start pulse -> Done 22 cycles later, Out=128'h6353e08c0960e104cd70b751bacad0ec (In XOR 0xB), exactly 11 RoundValid pulses with RoundNum 0..10 and Mode sequence 0,1x9,2.
REQ-037 SHALL cover: same stub with LAT=3 -> Done 44 cycles after Start, same Out, RoundIn stable throughout each WAIT.
REQ-038 SHALL cover: Start held high continuously, In changed to 128'ha7be1a6997ad739bd8c9ca451f618b61 mid-run -> first result unaffected; second block starts the cycle after Done; Out=128'ha7be1a6997ad739bd8c9ca451f618b6a after its Done.
REQ-039 SHALL cover: Rst_n pulsed low in WAIT of round 5 -> all outputs 0 asynchronously, no Done; a fresh Start after release completes normally in 22 cycles.
REQ-040 SHALL cover: integration with the real AES round datapath, key 000102030405060708090a0b0c0d0e0f, In=00112233445566778899aabbccddeeff -> Out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-041 SHALL cover: after one completed block, Start low for 50 cycles -> Out stable, Busy=0, no RoundValid activity.

Source files
------------

// File: rtl/aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_seq
// Brief    : Round sequencer for an AES-128 encryption core. It loads a block,
//            issues rounds 0..10 to an external round datapath, waits LAT
//            cycles for each result, and presents the final state as ciphertext.
// Revision : 1.0  initial release
// ============================================================================
module aes_round_seq #(
  parameter int LAT = 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Start,
  input  logic [127:0] In,
  input  logic [127:0] RoundOut,
  output logic [127:0] RoundIn,
  output logic [3:0]   RoundNum,
  output logic [1:0]   Mode,
  output logic         RoundValid,
  output logic         Busy,
  output logic         Done,
  output logic [127:0] Out
);

  // The wait counter starts at 0 in the first WAIT cycle, so the LAT-th WAIT
  // cycle is the one where the counter reads LAT-1.
  localparam logic [3:0] LAST_WAIT   = 4'(LAT - 1);
  localparam logic [3:0] FINAL_ROUND = 4'd10;

  localparam logic [1:0] MODE_ARK   = 2'd0;
  localparam logic [1:0] MODE_FULL  = 2'd1;
  localparam logic [1:0] MODE_FINAL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [127:0] st;
  logic [3:0]   wait_cnt;

  // The datapath always sees the working state; it only changes on a capture
  // edge or a block load, so it is stable across ISSUE and WAIT.
  assign RoundIn = st;

  // Datapath mode follows the round index: initial key add, full rounds, final round.
  always_comb begin
    Mode = MODE_FULL;
    if (RoundNum == 4'd0) begin
      Mode = MODE_ARK;
    end else if (RoundNum == FINAL_ROUND) begin
      Mode = MODE_FINAL;
    end
  end

  // Sequencer: state, working register, round index, wait counter and all
  // registered outputs. Start is only looked at in IDLE, so requests while
  // busy are dropped rather than queued.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      st         <= '0;
      RoundNum   <= '0;
      wait_cnt   <= '0;
      Out        <= '0;
      RoundValid <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      RoundValid <= 1'b0;
      Done       <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            st         <= In;
            RoundNum   <= '0;
            state      <= ISSUE;
            RoundValid <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            st <= RoundOut;
            if (RoundNum == FINAL_ROUND) begin
              // Out is loaded with the same value going into st, so it is
              // valid in the Done cycle and held until the next completion.
              Out   <= RoundOut;
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              RoundNum   <= RoundNum + 4'd1;
              RoundValid <= 1'b1;
              state      <= ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_seq
// Brief    : Directed bench for aes_round_seq. One instance (LAT=1) runs against
//            an XOR stub or an AES-128 round model; a second (LAT=3) runs the stub.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, start3, use_aes;
  logic [127:0] in_blk, in3;
  logic [127:0] round_out, round_in, out_blk;
  logic [127:0] round_out3, round_in3, out3;
  logic [3:0]   round_num, round_num3;
  logic [1:0]   mode, mode3;
  logic         round_valid, busy, done;
  logic         round_valid3, busy3, done3;

  int errors = 0;
  int checks = 0;

  aes_round_seq #(.LAT(1)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .In(in_blk), .RoundOut(round_out),
    .RoundIn(round_in), .RoundNum(round_num), .Mode(mode), .RoundValid(round_valid),
    .Busy(busy), .Done(done), .Out(out_blk)
  );

  aes_round_seq #(.LAT(3)) dut3 (
    .Clk(clk), .Rst_n(rst_n), .Start(start3), .In(in3), .RoundOut(round_out3),
    .RoundIn(round_in3), .RoundNum(round_num3), .Mode(mode3), .RoundValid(round_valid3),
    .Busy(busy3), .Done(done3), .Out(out3)
  );

  // ---------------- AES-128 round model (bench-side datapath) ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk   [11];
  logic [31:0]  w    [44];
  logic [31:0]  tmp;
  logic [7:0]   rcon;
  logic [127:0] key;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_of(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    if (v != 8'h00) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, v);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [3:0] rn,
                                             input logic [1:0] md);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    if (md == 2'd0) return s ^ rk[rn];
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    for (int i = 0; i < 16; i++) b[i] = t[i];
    if (md == 2'd1) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ rk[rn];
  endfunction

  // External datapaths: XOR stub or real AES round (LAT=1 instance), XOR stub (LAT=3).
  always_comb begin
    round_out = round_in ^ {124'b0, round_num};
    if (use_aes) round_out = aes_round(round_in, round_num, mode);
  end
  assign round_out3 = round_in3 ^ {124'b0, round_num3};

  // ---------------- Monitors ----------------
  int           rv_cnt   = 0;
  int           rv3_cnt  = 0;
  int           done_cnt = 0;
  int           stab_err = 0;
  logic [3:0]   rn_log [256];
  logic [1:0]   md_log [256];
  logic [127:0] hold3 = '0;

  always @(posedge clk) begin
    if (round_valid) begin
      rn_log[rv_cnt[7:0]] <= round_num;
      md_log[rv_cnt[7:0]] <= mode;
      rv_cnt <= rv_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (round_valid3) begin
      rv3_cnt <= rv3_cnt + 1;
      hold3   <= round_in3;
    end else if (busy3 && !done3 && round_in3 !== hold3) begin
      stab_err <= stab_err + 1;
    end
  end

  // ---------------- Helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  localparam logic [127:0] X_BLK = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] X_EXP = 128'h6353e08c0960e104cd70b751bacad0ec;
  localparam logic [127:0] P_BLK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P_EXP = 128'h00112233445566778899aabbccddeef4;
  localparam logic [127:0] B_BLK = 128'ha7be1a6997ad739bd8c9ca451f618b61;
  localparam logic [127:0] B_EXP = 128'ha7be1a6997ad739bd8c9ca451f618b6a;
  localparam logic [127:0] AES_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int         n, base, base3, sbase, dbase;
  logic [1:0] em;

  initial begin
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; use_aes = 1'b0;
    in_blk = '0; in3 = '0;

    // Build S-box and AES-128 key schedule for key 000102..0f.
    for (int v = 0; v < 256; v++) sbox[v] = sbox_of(8'(v));
    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Reset state.
    tick(); tick();
    check("rst_out", out_blk, '0);
    check("rst_roundin", round_in, '0);
    check("rst_roundnum", 128'(round_num), 0);
    check("rst_mode", 128'(mode), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    check("rst_rv", 128'(round_valid), 0);

    // Stub, LAT=1; Start offered together with reset release.
    base = rv_cnt;
    rst_n = 1'b1; start = 1'b1; in_blk = X_BLK;
    tick();
    start = 1'b0;
    check("t1_busy", 128'(busy), 1);
    check("t1_rv", 128'(round_valid), 1);
    check("t1_roundin", round_in, X_BLK);
    check("t1_mode0", 128'(mode), 0);
    wait_done(n);
    check("t1_latency", 128'(n), 22);
    check("t1_out", out_blk, X_EXP);
    check("t1_rv_count", 128'(rv_cnt - base), 11);
    for (int k = 0; k < 11; k++) begin
      em = (k == 0) ? 2'd0 : ((k == 10) ? 2'd2 : 2'd1);
      check("t1_rn_seq", 128'(rn_log[8'(base + k)]), 128'(k));
      check("t1_mode_seq", 128'(md_log[8'(base + k)]), 128'(em));
    end
    tick();
    check("t1_done_1cyc", 128'(done), 0);
    check("t1_idle_busy", 128'(busy), 0);
    check("t1_idle_rn", 128'(round_num), 10);
    check("t1_idle_mode", 128'(mode), 2);
    check("t1_idle_roundin", round_in, X_EXP);

    // Idle for 50 cycles.
    base = rv_cnt;
    repeat (50) tick();
    check("idle_out", out_blk, X_EXP);
    check("idle_busy", 128'(busy), 0);
    check("idle_rv", 128'(rv_cnt - base), 0);

    // Stub, LAT=3.
    base3 = rv3_cnt; sbase = stab_err;
    start3 = 1'b1; in3 = X_BLK;
    tick();
    start3 = 1'b0;
    n = 0;
    while (done3 !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("lat3_latency", 128'(n), 44);
    check("lat3_out", out3, X_EXP);
    check("lat3_mode", 128'(mode3), 2);
    check("lat3_rv_count", 128'(rv3_cnt - base3), 11);
    check("lat3_stable", 128'(stab_err - sbase), 0);

    // Start held high, In changed mid-run.
    start = 1'b1; in_blk = P_BLK;
    tick();
    repeat (5) tick();
    in_blk = B_BLK;
    check("hold_out_prev", out_blk, X_EXP);
    wait_done(n);
    check("hold_latency1", 128'(n), 17);
    check("hold_out1", out_blk, P_EXP);
    tick();
    check("hold_idle_busy", 128'(busy), 0);
    tick();
    start = 1'b0;
    check("hold_restart_busy", 128'(busy), 1);
    check("hold_restart_in", round_in, B_BLK);
    check("hold_out_kept", out_blk, P_EXP);
    wait_done(n);
    check("hold_latency2", 128'(n), 22);
    check("hold_out2", out_blk, B_EXP);
    tick();
    tick();
    check("hold_no_third", 128'(busy), 0);

    // Reset in WAIT of round 5.
    start = 1'b1; in_blk = X_BLK;
    tick();
    start = 1'b0;
    n = 0;
    while (!(round_valid === 1'b1 && round_num === 4'd5) && n < 100) begin
      tick();
      n++;
    end
    tick();
    dbase = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", out_blk, '0);
    check("arst_roundin", round_in, '0);
    check("arst_rn", 128'(round_num), 0);
    check("arst_busy", 128'(busy), 0);
    check("arst_rv", 128'(round_valid), 0);
    check("arst_done", 128'(done), 0);
    repeat (3) tick();
    check("arst_no_done", 128'(done_cnt - dbase), 0);
    check("arst_held_idle", 128'(busy), 0);
    rst_n = 1'b1; start = 1'b1; in_blk = X_BLK;
    tick();
    start = 1'b0;
    check("arst_restart_busy", 128'(busy), 1);
    wait_done(n);
    check("arst_latency", 128'(n), 22);
    check("arst_out_new", out_blk, X_EXP);

    // Real AES-128 round datapath.
    tick();
    use_aes = 1'b1;
    start = 1'b1; in_blk = P_BLK;
    tick();
    start = 1'b0;
    wait_done(n);
    check("aes_latency", 128'(n), 22);
    check("aes_out", out_blk, AES_CT);
    tick();
    use_aes = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
